// File: rtl/reg_file_if.sv
// reg_file_if -- bus bundle between the register file and the unit driving it.
//
// Purpose: groups the read ports, the general write port, the frame-base
// adjust controls and the status outputs of reg_file. Clock and reset are
// not part of this bundle.
//
// Signals:
//   reg1, reg2   read indices (4 bits each)
//   rd1, rd2     read data for reg1 / reg2 (DATA_W bits)
//   wr_en        general write enable
//   wr_reg       write index (4 bits)
//   wr_data      write data (DATA_W bits)
//   fb_inc       increment frame base r13
//   fb_dec       decrement frame base r13
//   acc_out      current contents of accumulator r15
//   fb_out       current contents of frame base r13
//   acc_zero     registered flag, 1 when r15 == 0
//
// Modports:
//   master  the controller side (drives indices, write port, adjusts)
//   slave   the register file side
interface reg_file_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        reg1;
   logic [3:0]        reg2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              wr_en;
   logic [3:0]        wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic              fb_inc;
   logic              fb_dec;
   logic [DATA_W-1:0] acc_out;
   logic [DATA_W-1:0] fb_out;
   logic              acc_zero;

   modport master (
      output reg1, reg2, wr_en, wr_reg, wr_data, fb_inc, fb_dec,
      input  rd1, rd2, acc_out, fb_out, acc_zero
   );

   modport slave (
      input  reg1, reg2, wr_en, wr_reg, wr_data, fb_inc, fb_dec,
      output rd1, rd2, acc_out, fb_out, acc_zero
   );
endinterface

// File: rtl/reg_file.sv
// reg_file -- sixteen-entry register file with accumulator and frame base.
//
// Purpose: holds r0-r15 of DATA_W bits. r15 is the accumulator (exposed on
// acc_out with a registered zero flag), r13 is the frame base (exposed on
// fb_out, with its own increment/decrement path). Two combinational read
// ports, one synchronous write port.
//
// Parameters:
//   DATA_W    register width
//   FB_RESET  value loaded into r13 on reset
//
// Ports:
//   clk       single clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   bus       reg_file_if.slave: read ports, write port, fb adjust,
//             acc_out / fb_out / acc_zero status
module reg_file #(
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] FB_RESET = 8'h00
) (
   input logic         clk,
   input logic         reset,
   reg_file_if.slave   bus
);

   localparam logic [3:0]        FB_IDX  = 4'd13;
   localparam logic [3:0]        ACC_IDX = 4'd15;
   localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs [16];
   logic              acc_zero_q;
   logic              fb_written;
   logic [DATA_W-1:0] acc_next;

   // A general write to r13 takes precedence over the adjust path.
   assign fb_written = bus.wr_en && (bus.wr_reg == FB_IDX);

   // Value r15 will hold after this edge, so acc_zero tracks acc_out
   // in the same cycle instead of lagging one behind.
   assign acc_next = (bus.wr_en && (bus.wr_reg == ACC_IDX)) ? bus.wr_data
                                                             : regs[ACC_IDX];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
         regs[FB_IDX] <= FB_RESET;
         acc_zero_q   <= 1'b1;
      end else begin
         if (bus.wr_en) begin
            regs[bus.wr_reg] <= bus.wr_data;
         end
         // Inc and dec together cancel out and leave r13 alone.
         if (!fb_written) begin
            if (bus.fb_inc && !bus.fb_dec) begin
               regs[FB_IDX] <= regs[FB_IDX] + ONE;
            end else if (bus.fb_dec && !bus.fb_inc) begin
               regs[FB_IDX] <= regs[FB_IDX] - ONE;
            end
         end
         acc_zero_q <= (acc_next == '0);
      end
   end

   // Reads come straight from storage; a write lands one cycle later.
   assign bus.rd1      = regs[bus.reg1];
   assign bus.rd2      = regs[bus.reg2];
   assign bus.acc_out  = regs[ACC_IDX];
   assign bus.fb_out   = regs[FB_IDX];
   assign bus.acc_zero = acc_zero_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- directed self-checking bench for reg_file.
//
// Drives the interface master side, advances one clock per step and
// compares outputs against hand-computed values shortly after each edge.
module tb_reg_file;

   localparam logic [7:0] FB_RST = 8'h3C;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   reg_file_if #(.DATA_W(8)) bus ();

   reg_file #(
      .DATA_W   (8),
      .FB_RESET (FB_RST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of write/adjust controls, clock it, then go idle.
   task automatic applyStimulus(input logic we, input logic [3:0] wreg,
                                input logic [7:0] wdata,
                                input logic inc, input logic dec);
      bus.wr_en   = we;
      bus.wr_reg  = wreg;
      bus.wr_data = wdata;
      bus.fb_inc  = inc;
      bus.fb_dec  = dec;
      tick();
      bus.wr_en  = 1'b0;
      bus.fb_inc = 1'b0;
      bus.fb_dec = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] e1;
      logic [7:0] e2;

      bus.reg1    = 4'd0;
      bus.reg2    = 4'd0;
      bus.wr_en   = 1'b0;
      bus.wr_reg  = 4'd0;
      bus.wr_data = 8'h00;
      bus.fb_inc  = 1'b0;
      bus.fb_dec  = 1'b0;

      // Reset wins over a concurrent write to r15 and an fb increment.
      reset = 1'b1;
      applyStimulus(1'b1, 4'd15, 8'h55, 1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("rst_acc_zero", {7'b0, bus.acc_zero}, 8'h01);
      checkOutput("rst_acc_out", bus.acc_out, 8'h00);
      checkOutput("rst_fb_out", bus.fb_out, FB_RST);
      for (int i = 0; i < 16; i++) begin
         bus.reg1 = 4'(i);
         bus.reg2 = 4'(15 - i);
         #1;
         e1 = (i == 13) ? FB_RST : 8'h00;
         e2 = ((15 - i) == 13) ? FB_RST : 8'h00;
         checkOutput($sformatf("rst_rd1_r%0d", i), bus.rd1, e1);
         checkOutput($sformatf("rst_rd2_r%0d", 15 - i), bus.rd2, e2);
      end

      // Write r3; no bypass during the write cycle.
      bus.reg1    = 4'd3;
      bus.reg2    = 4'd3;
      bus.wr_en   = 1'b1;
      bus.wr_reg  = 4'd3;
      bus.wr_data = 8'hA5;
      #1;
      checkOutput("nobypass_rd1", bus.rd1, 8'h00);
      tick();
      bus.wr_en = 1'b0;
      checkOutput("wr_r3_rd1", bus.rd1, 8'hA5);
      checkOutput("wr_r3_rd2", bus.rd2, 8'hA5);

      // Frame base wrap in both directions, and inc+dec cancelling.
      applyStimulus(1'b1, 4'd13, 8'hFF, 1'b0, 1'b0);
      checkOutput("fb_load_ff", bus.fb_out, 8'hFF);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      checkOutput("fb_inc_wrap", bus.fb_out, 8'h00);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
      checkOutput("fb_dec_wrap", bus.fb_out, 8'hFF);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
      checkOutput("fb_both_hold", bus.fb_out, 8'hFF);

      // General write to r13 overrides the adjust path.
      applyStimulus(1'b1, 4'd13, 8'h10, 1'b0, 1'b0);
      checkOutput("fb_load_10", bus.fb_out, 8'h10);
      applyStimulus(1'b1, 4'd13, 8'h40, 1'b1, 1'b0);
      checkOutput("fb_wr_priority", bus.fb_out, 8'h40);
      // A write elsewhere leaves the adjust path active.
      applyStimulus(1'b1, 4'd2, 8'h77, 1'b0, 1'b1);
      checkOutput("fb_dec_with_wr", bus.fb_out, 8'h3F);
      bus.reg1 = 4'd2;
      #1;
      checkOutput("wr_r2", bus.rd1, 8'h77);
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      checkOutput("fb_inc_plain", bus.fb_out, 8'h40);

      // Accumulator and its zero flag move together.
      applyStimulus(1'b1, 4'd15, 8'h01, 1'b0, 1'b0);
      checkOutput("acc_out_01", bus.acc_out, 8'h01);
      checkOutput("acc_zero_01", {7'b0, bus.acc_zero}, 8'h00);
      applyStimulus(1'b1, 4'd15, 8'h00, 1'b0, 1'b0);
      checkOutput("acc_out_00", bus.acc_out, 8'h00);
      checkOutput("acc_zero_00", {7'b0, bus.acc_zero}, 8'h01);
      applyStimulus(1'b1, 4'd15, 8'h80, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
      checkOutput("acc_zero_other_wr", {7'b0, bus.acc_zero}, 8'h00);

      // Fill every register with index*0x11, then read them all back.
      for (int i = 0; i < 16; i++) begin
         v = 8'(i * 17);
         applyStimulus(1'b1, 4'(i), v, 1'b0, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         bus.reg1 = 4'(i);
         bus.reg2 = 4'(15 - i);
         #1;
         checkOutput($sformatf("sweep_rd1_r%0d", i), bus.rd1, 8'(i * 17));
         checkOutput($sformatf("sweep_rd2_r%0d", 15 - i), bus.rd2,
                     8'((15 - i) * 17));
      end
      checkOutput("sweep_acc_out", bus.acc_out, 8'hFF);
      checkOutput("sweep_acc_zero", {7'b0, bus.acc_zero}, 8'h00);
      checkOutput("sweep_fb_out", bus.fb_out, 8'hDD);

      // Mid-run reset beats an fb decrement and a write.
      reset = 1'b1;
      applyStimulus(1'b1, 4'd3, 8'h99, 1'b0, 1'b1);
      reset = 1'b0;
      bus.reg1 = 4'd3;
      bus.reg2 = 4'd14;
      #1;
      checkOutput("rst2_r3", bus.rd1, 8'h00);
      checkOutput("rst2_r14", bus.rd2, 8'h00);
      checkOutput("rst2_fb_out", bus.fb_out, FB_RST);
      checkOutput("rst2_acc_zero", {7'b0, bus.acc_zero}, 8'h01);

      // First edge after reset already accepts writes and adjusts.
      applyStimulus(1'b1, 4'd3, 8'h5A, 1'b1, 1'b0);
      checkOutput("post_rst_wr", bus.rd1, 8'h5A);
      checkOutput("post_rst_inc", bus.fb_out, 8'h3D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
